alu_frame_packer: RTL and testbench

//  Parametrised next-generation framer for the ALU datapath. Buffers alu_result words in a FIFO and emits them
//  as length-delimited frames over a valid/ready stream. Adds downstream backpressure, a last-word marker,

---
 rtl/alu_pkg.sv | 21 ++
 rtl/alu_frame_fifo.sv | 51 +++++
 rtl/alu_frame_packer.sv | 138 +++++++++++++
 tb/tb_alu_frame_packer.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types and defaults for the ALU frame packer.
// Holds the framer state enum, default parameter values and the checksum fold step.
package alu_pkg;

  localparam int DEF_DATA_W     = 32;
  localparam int DEF_LEN_W      = 5;
  localparam int DEF_FIFO_DEPTH = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    CSUM
  } frame_state_e;

  // One step of the running frame checksum: XOR of every data word sent in the frame.
  function automatic logic [DEF_DATA_W-1:0] csum_step(input logic [DEF_DATA_W-1:0] acc,
                                                      input logic [DEF_DATA_W-1:0] word);
    return acc ^ word;
  endfunction

endpackage

// File: rtl/alu_frame_fifo.sv
// Synchronous show-ahead FIFO for the frame packer.
// The head word is visible on rdata whenever empty is low; a word written on one edge is
// readable from the following cycle. Pointers carry an extra wrap bit so full and empty
// are distinguished without a separate occupancy counter.
module alu_frame_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] wdata,
  input  logic              pop,
  output logic [DATA_W-1:0] rdata,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;

  // Storage write.
  // NOTE: the data array is deliberately left out of reset; the pointers alone define
  // which entries are valid, and a reset on the array would block RAM inference.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  // Pointer update; the caller only asserts push/pop when they are legal.
  // NOTE: sequential state uses non-blocking assignments so every register samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/alu_frame_packer.sv
// ALU result framer: buffers alu_result words and emits length-delimited frames on a
// valid/ready stream, with backpressure, overflow and length-error reporting.
// Build option: define ALU_FRAME_CSUM_EN to append an XOR checksum word to every frame;
// frame_last then marks the checksum word instead of the last data word.
module alu_frame_packer
  import alu_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int LEN_W      = DEF_LEN_W,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              alu_ready,
  input  logic [DATA_W-1:0] alu_result,
  input  logic              frame_len_val,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              frame_rdy,
  output logic              frame_valid,
  output logic [DATA_W-1:0] frame_data,
  output logic              frame_last,
  output logic              frame,
  output logic              frame_bp,
  output logic              ovf,
  output logic              len_err
);

  frame_state_e      state_q, state_d;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  cnt_q;
  logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_head;
  logic              last_word;
  logic              len_accept;

  // A pop only happens on a data transfer; a full FIFO still accepts a push in that cycle.
  assign fifo_pop   = (state_q == ACTIVE) && frame_valid && frame_rdy;
  assign fifo_push  = alu_ready && (!fifo_full || fifo_pop);
  assign last_word  = (cnt_q == (len_q - LEN_W'(1)));
  assign len_accept = (state_q == IDLE) && frame_len_val && (frame_len != '0);
  assign frame_bp   = fifo_full;

  alu_frame_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (alu_result),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

`ifdef ALU_FRAME_CSUM_EN
  logic [DATA_W-1:0] csum_q, csum_upd;

  if (DATA_W == DEF_DATA_W) begin : g_csum_pkg
    assign csum_upd = csum_step(csum_q, fifo_head);
  end else begin : g_csum_raw
    assign csum_upd = csum_q ^ fifo_head;
  end

  // Running checksum: cleared when a frame is opened, folded on every data transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      csum_q <= '0;
    end else if (len_accept) begin
      csum_q <= '0;
    end else if (fifo_pop) begin
      csum_q <= csum_upd;
    end
  end
`endif

  // Next-state and stream outputs; the state register alone decides what is presented.
  // NOTE: every output of this block gets a default first so no path can infer a latch.
  always_comb begin
    state_d     = state_q;
    frame       = 1'b0;
    frame_valid = 1'b0;
    frame_data  = '0;
    frame_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (len_accept) state_d = ACTIVE;
      end
      ACTIVE: begin
        frame       = 1'b1;
        frame_valid = !fifo_empty;
        frame_data  = fifo_head;
        if (last_word && frame_valid) begin
`ifdef ALU_FRAME_CSUM_EN
          if (frame_rdy) state_d = CSUM;
`else
          frame_last = 1'b1;
          if (frame_rdy) state_d = IDLE;
`endif
        end
      end
`ifdef ALU_FRAME_CSUM_EN
      CSUM: begin
        frame       = 1'b1;
        frame_valid = 1'b1;
        frame_data  = csum_q;
        frame_last  = 1'b1;
        if (frame_rdy) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // State, frame length/count and error flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      cnt_q   <= '0;
      ovf     <= 1'b0;
      len_err <= 1'b0;
    end else begin
      state_q <= state_d;
      // A length strobe is only honoured in IDLE; zero length or an open frame rejects it.
      len_err <= frame_len_val && ((state_q != IDLE) || (frame_len == '0));
      if (alu_ready && fifo_full && !fifo_pop) ovf <= 1'b1;
      if (len_accept) begin
        len_q <= frame_len;
        cnt_q <= '0;
      end else if (fifo_pop) begin
        cnt_q <= cnt_q + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_alu_frame_packer.sv
// Self-checking bench for alu_frame_packer. A cycle model (word queue, frame state,
// checksum, error flags) is updated from the driven stimulus; every DUT output is
// compared against it on the falling edge.
module tb_alu_frame_packer;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 5;
  localparam int DEPTH  = 8;
`ifdef ALU_FRAME_CSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              alu_ready = 1'b0;
  logic [DATA_W-1:0] alu_result = '0;
  logic              frame_len_val = 1'b0;
  logic [LEN_W-1:0]  frame_len = '0;
  logic              frame_rdy = 1'b0;
  logic              frame_valid;
  logic [DATA_W-1:0] frame_data;
  logic              frame_last;
  logic              frame;
  logic              frame_bp;
  logic              ovf;
  logic              len_err;

  always #5 clk = ~clk;

  alu_frame_packer #(
    .DATA_W     (DATA_W),
    .LEN_W      (LEN_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .alu_ready     (alu_ready),
    .alu_result    (alu_result),
    .frame_len_val (frame_len_val),
    .frame_len     (frame_len),
    .frame_rdy     (frame_rdy),
    .frame_valid   (frame_valid),
    .frame_data    (frame_data),
    .frame_last    (frame_last),
    .frame         (frame),
    .frame_bp      (frame_bp),
    .ovf           (ovf),
    .len_err       (len_err)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard / model state
  logic [DATA_W-1:0] model_q[$];
  int                m_state = 0;   // 0 idle, 1 active, 2 checksum
  int                m_len   = 0;
  int                m_cnt   = 0;
  logic [DATA_W-1:0] m_csum  = '0;
  bit                m_ovf   = 1'b0;
  bit                m_lerr  = 1'b0;
  int                xfers   = 0;

  int                occ;
  bit                exp_valid, exp_last, xfer, do_push;
  logic [DATA_W-1:0] exp_data;

  // Compare outputs against the model, then advance the model by the inputs of this cycle.
  always @(negedge clk) begin
    if (rst) begin
      model_q.delete();
      m_state = 0; m_len = 0; m_cnt = 0; m_csum = '0; m_ovf = 1'b0; m_lerr = 1'b0;
    end else begin
      occ       = model_q.size();
      exp_valid = (m_state == 1) ? (occ > 0) : (m_state == 2);
      exp_last  = 1'b0;
      exp_data  = '0;
      if (m_state == 1 && occ > 0) begin
        exp_data = model_q[0];
        exp_last = !CSUM_EN && (m_cnt == m_len - 1);
      end
      if (m_state == 2) begin
        exp_data = m_csum;
        exp_last = 1'b1;
      end
      check("frame", frame, m_state != 0);
      check("frame_valid", frame_valid, exp_valid);
      check("frame_last", frame_last, exp_last);
      if (exp_valid) check("frame_data", frame_data, exp_data);
      check("frame_bp", frame_bp, occ == DEPTH);
      check("ovf", ovf, m_ovf);
      check("len_err", len_err, m_lerr);

      xfer    = exp_valid && frame_rdy;
      m_lerr  = frame_len_val && (m_state != 0 || frame_len == '0);
      do_push = 1'b0;
      if (alu_ready) begin
        if (occ < DEPTH || (xfer && m_state == 1)) do_push = 1'b1;
        else m_ovf = 1'b1;
      end
      if (xfer) begin
        xfers++;
        if (m_state == 2) begin
          m_state = 0;
        end else begin
          void'(model_q.pop_front());
          m_csum ^= exp_data;
          m_cnt++;
          if (m_cnt == m_len) m_state = CSUM_EN ? 2 : 0;
        end
      end else if (m_state == 0 && frame_len_val && frame_len != '0) begin
        m_state = 1; m_len = int'(frame_len); m_cnt = 0; m_csum = '0;
      end
      if (do_push) model_q.push_back(alu_result);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DATA_W-1:0] d);
    alu_ready  = 1'b1;
    alu_result = d;
    tick();
    alu_ready  = 1'b0;
  endtask

  task automatic start_frame(input int len);
    frame_len_val = 1'b1;
    frame_len     = LEN_W'(len);
    tick();
    frame_len_val = 1'b0;
  endtask

  task automatic do_reset(input int cycles);
    rst = 1'b1;
    repeat (cycles) tick();
    rst = 1'b0;
  endtask

  // Bounded wait for the model frame to close; toggles frame_rdy when asked.
  task automatic wait_idle(input bit toggle_rdy);
    int n = 0;
    while (m_state != 0 && n < 200) begin
      if (toggle_rdy) frame_rdy = ~frame_rdy;
      tick();
      n++;
    end
    if (m_state != 0) check("idle_timeout", 64'd0, 64'd1);
  endtask

  int x0;

  initial begin
    do_reset(2);

    // 1: reset in the middle of an open frame
    frame_rdy = 1'b0;
    start_frame(3);
    push_word(32'hA1);
    push_word(32'hA2);
    do_reset(2);
    @(negedge clk);
    check("rst_outputs", {frame_valid, frame_data, frame_last, frame, frame_bp, ovf, len_err}, '0);
    tick();

    // 2: len 3, words streamed with rdy high
    frame_rdy = 1'b1;
    x0 = xfers;
    start_frame(3);
    push_word(32'h11);
    push_word(32'h22);
    push_word(32'h33);
    wait_idle(1'b0);
    check("t2_xfers", 64'(xfers - x0), CSUM_EN ? 64'd4 : 64'd3);
    check("t2_csum", m_csum, 64'h0);

    // 3: overfill while stalled, then drain eight words
    frame_rdy = 1'b0;
    for (int i = 0; i < 9; i++) push_word(32'h300 + 32'(i));
    @(negedge clk);
    check("t3_bp", frame_bp, 1);
    check("t3_ovf", ovf, 1);
    tick();
    frame_rdy = 1'b1;
    x0 = xfers;
    start_frame(8);
    wait_idle(1'b0);
    check("t3_xfers", 64'(xfers - x0), CSUM_EN ? 64'd9 : 64'd8);
    check("t3_empty", 64'(model_q.size()), 64'd0);

    // 4: len 4 with frame_rdy toggling every cycle
    frame_rdy = 1'b0;
    for (int i = 0; i < 4; i++) push_word(32'h4400 + 32'(i));
    x0 = xfers;
    start_frame(4);
    frame_rdy = 1'b1;
    wait_idle(1'b1);
    check("t4_xfers", 64'(xfers - x0), CSUM_EN ? 64'd5 : 64'd4);

    // 5: zero length in IDLE, and a length strobe inside an open frame
    frame_rdy = 1'b0;
    start_frame(0);
    push_word(32'h5A);
    push_word(32'h5B);
    push_word(32'h5C);
    start_frame(2);
    tick();
    start_frame(7);
    frame_rdy = 1'b1;
    wait_idle(1'b0);
    check("t5_left", 64'(model_q.size()), 64'd1);
    start_frame(1);
    wait_idle(1'b0);

    // 6: full FIFO with a pop and a push in the same cycle
    do_reset(1);
    frame_rdy = 1'b0;
    for (int i = 0; i < 8; i++) push_word(32'h600 + 32'(i));
    start_frame(8);
    frame_rdy  = 1'b1;
    push_word(32'h6FF);
    wait_idle(1'b0);
    @(negedge clk);
    check("t6_ovf", ovf, 0);
    check("t6_left", 64'(model_q.size()), 64'd1);
    tick();
    start_frame(1);
    wait_idle(1'b0);
    check("t6_empty", 64'(model_q.size()), 64'd0);

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected done");
    $fatal(1, "timeout");
  end

endmodule
